// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the read arbiter and its
// read-mux.
package regfile_pkg;
  localparam int REG_COUNT = 32;
  localparam int DATA_W = 64;
  localparam logic [4:0] ZR_IDX = 5'd31;

  typedef logic [4:0] reg_idx_t;
  typedef logic [63:0] reg_data_t;
endpackage

// File: rtl/regfile_read_arbiter_if.sv
// Requester-side bus of the register-file read arbiter.
// Handshake: req is level and held until gnt; gnt pulses in the same cycle.
// rvalid/rid/rdata follow exactly one cycle after each gnt.
interface regfile_read_arbiter_if
  import regfile_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
);
  logic stall;
  logic [NREQ-1:0] req;
  reg_idx_t [NREQ-1:0] addr;
  logic [NREQ-1:0] gnt;
  logic rvalid;
  logic [ID_W-1:0] rid;
  reg_data_t rdata;
  logic busy;
  logic [ID_W-1:0] rr_ptr;

  modport master (
    output stall, req, addr,
    input gnt, rvalid, rid, rdata, busy, rr_ptr
  );

  modport slave (
    input stall, req, addr,
    output gnt, rvalid, rid, rdata, busy, rr_ptr
  );
endinterface

// File: rtl/mux32_1_64.sv
// 32:1 selection of one 64-bit register from the flattened register array.
module mux32_1_64
  import regfile_pkg::*;
(
  input  logic [REG_COUNT-1:0][DATA_W-1:0] din,
  input  reg_idx_t                         sel,
  output reg_data_t                        dout
);
  assign dout = din[sel];
endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin pick: rotate req so rr_ptr sits at bit 0,
// take the lowest set bit, then rotate the index back.
module rr_pick #(
  parameter int NREQ = 4,
  localparam int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] rr_ptr,
  output logic [NREQ-1:0] win,
  output logic [ID_W-1:0] win_id,
  output logic            any
);
  logic [NREQ-1:0] rot;
  int off;
  int idx;

  always_comb begin
    rot = '0;
    off = 0;
    idx = 0;
    any = 1'b0;
    win = '0;
    win_id = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      for (int j = 0; j < NREQ; j++) begin
        if (idx == j) rot[k] = req[j];
      end
    end
    // Descending scan so the lowest set bit is the one left in off.
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        off = k;
        any = 1'b1;
      end
    end
    idx = int'(rr_ptr) + off;
    if (idx >= NREQ) idx = idx - NREQ;
    win_id = ID_W'(idx);
    for (int j = 0; j < NREQ; j++) begin
      win[j] = any && (idx == j);
    end
  end
endmodule

// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read mux among NREQ
// requesters; read data returns registered one cycle after the grant.
module regfile_read_arbiter
  import regfile_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [REG_COUNT-1:0][DATA_W-1:0] regs,
  regfile_read_arbiter_if.slave            bus
);
  localparam int ID_W = $clog2(NREQ);

  logic [ID_W-1:0] rr_ptr;
  logic [NREQ-1:0] win;
  logic [ID_W-1:0] win_id;
  logic            any;
  logic            take;
  reg_idx_t        sel_addr;
  reg_data_t       mux_out;
  reg_data_t       rd_next;
  logic            rvalid;
  logic [ID_W-1:0] rid;
  reg_data_t       rdata;
  logic            busy;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_ptr),
    .win    (win),
    .win_id (win_id),
    .any    (any)
  );

  mux32_1_64 u_mux (
    .din  (regs),
    .sel  (sel_addr),
    .dout (mux_out)
  );

  // Stall beats any pending request; reset masks gnt combinationally.
  assign take     = any && !bus.stall;
  assign sel_addr = bus.addr[win_id];
  assign rd_next  = (sel_addr == ZR_IDX) ? '0 : mux_out;

  assign bus.gnt    = (take && !reset) ? win : '0;
  assign bus.rvalid = rvalid;
  assign bus.rid    = rid;
  assign bus.rdata  = rdata;
  assign bus.busy   = busy;
  assign bus.rr_ptr = rr_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid <= 1'b0;
      rid    <= '0;
      rdata  <= '0;
      busy   <= 1'b0;
      rr_ptr <= '0;
    end else begin
      busy   <= ($countones(bus.req) >= 2);
      rvalid <= take;
      if (take) begin
        rdata  <= rd_next;
        rid    <= win_id;
        rr_ptr <= (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + 1'b1;
      end
    end
  end
endmodule
